// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction-fetch front end: FSM encodings and the default datapath width.
package fetch_unit_pkg;

  localparam int unsigned FETCH_WIDTH = 32;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack channel plus the decode-side queue head.
interface fetch_unit_if #(
  parameter int unsigned WIDTH = 32
);

  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [WIDTH-1:0] imem_rdata;
  logic             instr_valid;
  logic [WIDTH-1:0] instr_data;
  logic [WIDTH-1:0] instr_pc;
  logic             instr_ready;

  // master is the fetch unit; slave is the memory/decode environment around it
  modport master (
    output imem_req, imem_addr, instr_valid, instr_data, instr_pc,
    input  imem_ack, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_data, instr_pc,
    output imem_ack, imem_rdata, instr_ready
  );

endinterface

// File: rtl/fetch_unit_queue.sv
// Circular instruction queue: DEPTH entries of {pc, instr}, clear has priority over push/pop.
module fetch_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ENTRY_W = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [ENTRY_W-1:0]         din,
  output logic [ENTRY_W-1:0]         head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q,  count_d;
  logic               do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign count = count_q;

  // head reads as zero when empty so stale storage never leaks onto the bus
  assign head = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: one outstanding imem request at a time, results queued for decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned WIDTH = FETCH_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_in,
  output logic             pc_advance,
  input  logic             flush,
  fetch_unit_if.master     bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] addr_q,  addr_d;
  logic             q_push;
  logic             q_empty, q_full;
  logic [PTR_W:0]   q_count;
  logic [2*WIDTH-1:0] q_head;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    q_push     = 1'b0;
    pc_advance = 1'b0;
    case (state_q)
      FETCH_IDLE: begin
        if ((q_count < (PTR_W+1)'(DEPTH)) && !flush) begin
          state_d = FETCH_REQ;
          addr_d  = pc_in;
        end
      end
      FETCH_REQ: begin
        if (bus.imem_ack) begin
          state_d = FETCH_IDLE;
          if (!flush) begin
            pc_advance = 1'b1;
            q_push     = ~q_full;
          end
        end else if (flush) begin
          state_d = FETCH_DRAIN;
        end
      end
      FETCH_DRAIN: begin
        if (bus.imem_ack) state_d = FETCH_IDLE;
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // request is outstanding in both REQ and DRAIN; address is only loaded on leaving IDLE
  assign bus.imem_req  = (state_q != FETCH_IDLE);
  assign bus.imem_addr = addr_q;

  fetch_queue #(
    .DEPTH   (DEPTH),
    .ENTRY_W (2*WIDTH)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (q_push),
    .pop   (bus.instr_ready),
    .clear (flush),
    .din   ({addr_q, bus.imem_rdata}),
    .head  (q_head),
    .count (q_count),
    .empty (q_empty),
    .full  (q_full)
  );

  assign bus.instr_valid = ~q_empty;
  assign bus.instr_pc    = q_head[2*WIDTH-1:WIDTH];
  assign bus.instr_data  = q_head[WIDTH-1:0];

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end and consumer of the PC register's output: samples pc_in, reads instruction memory over a req/ack handshake, and buffers fetched words in a small FIFO for decode.
- Drives pc_advance back to the PC's enable, so the PC steps exactly once per accepted fetch.
- A flush input discards queued and in-flight fetches when branch/jump logic redirects the PC.

Parameters:
- WIDTH, 32, data and address width; matches the PC width.
- DEPTH, 4, instruction queue entries (power of two, 2..16).
- PTR_W, clog2(DEPTH), queue pointer width (derived).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- pc_in  input  WIDTH  current PC value from the PC register.
- pc_advance  output  1  enable to PC; high one cycle per accepted fetch.
- flush  input  1  one-cycle redirect; discard all fetch state.
- imem_req  output  1  memory read request, held until ack.
- imem_addr  output  WIDTH  read address, stable while imem_req=1.
- imem_ack  input  1  memory completion strobe, one cycle, any latency ≥1.
- imem_rdata  input  WIDTH  read data, valid when imem_ack=1.
- instr_valid  output  1  queue head valid.
- instr_data  output  WIDTH  queue head instruction.
- instr_pc  output  WIDTH  address the head instruction was fetched from.
- instr_ready  input  1  decode accepts head this cycle.

Behaviour:
- Reset (reset=0, async): state=IDLE, queue empty.
  - imem_req=0, imem_addr=0, pc_advance=0, instr_valid=0, instr_data=0, instr_pc=0.
- States:
  - IDLE (no request outstanding).
  - REQ (request outstanding).
  - DRAIN (request outstanding, result to be discarded).
- IDLE -> REQ at the clock edge where count<DEPTH and flush=0.
  - On that edge: imem_addr<=pc_in, imem_req<=1.
- REQ, imem_ack=1, flush=0:
  - Push {imem_addr, imem_rdata} at the edge.
  - imem_req<=0, go IDLE.
  - pc_advance=1 combinationally in this cycle only.
- REQ, flush=1, imem_ack=1: data discarded, no push, pc_advance=0, go IDLE.
- REQ, flush=1, imem_ack=0: go DRAIN, imem_req stays 1 with address held.
- DRAIN:
  - On imem_ack, discard data, imem_req<=0, go IDLE.
  - A flush in DRAIN has no additional effect.
- pc_advance = (state==REQ) & imem_ack & ~flush. It is never high in IDLE or DRAIN.
- Only one request is ever outstanding; imem_addr never changes while imem_req=1.
- Issue check uses the queue count; with one outstanding and count<DEPTH at issue, a push can never overflow.
- Queue:
  - Circular buffer with rd/wr pointers wrapping modulo DEPTH; count is 0..DEPTH.
  - instr_valid = count!=0. instr_data and instr_pc are the head entry (registered storage, read combinationally).
  - Pop on instr_valid & instr_ready. Push and pop in the same cycle leave count unchanged.
  - instr_ready while empty is ignored.
- flush=1 empties the queue at the edge: pointers and count go to 0, and instr_valid=0 from the next cycle.
  - A pop in the same cycle is irrelevant.
  - flush has priority over push and pop.
- Timing with a zero-wait memory (ack the cycle after req):
  - Cycle 0: req issued.
  - Cycle 1: ack and pc_advance.
  - Cycle 2: instr_valid, new pc_in, state IDLE.
  - Cycle 3: next req.
  - Steady-state throughput: one fetch per 3 cycles.
- Full queue (count==DEPTH): stays IDLE with no request and pc_advance=0, so the PC holds.
- Reset mid-transaction: all state clears immediately. The memory side must tolerate an abandoned request.

Decomposition:
- Shared package: FETCH_IDLE/FETCH_REQ/FETCH_DRAIN state encodings (2 bits) and the default WIDTH=32.
- Sub-module fetch_queue: parameterised DEPTH×(2·WIDTH) synchronous FIFO.
  - Inputs: push, pop, clear.
  - Outputs: head, count, empty, full.
  - Same async active-low reset.
- The top level holds the FSM and the handshake.

Test Plan:
- Reset release with pc_in=0x00000000, zero-wait memory returning 0xA0000000+addr, instr_ready=1:
  - imem_addr sequence 0x0, 0x4, 0x8.
  - Exactly one pc_advance pulse per ack.
  - instr_data/instr_pc pairs match.
  - One issue every 3 cycles.
- instr_ready=0 for 20 cycles:
  - Exactly DEPTH=4 fetches, then imem_req stays 0 and pc_advance stays 0.
  - Raising instr_ready drains 4 entries in order, then fetching resumes.
- Memory latency 5 cycles:
  - imem_req high 5 cycles with a stable imem_addr.
  - pc_advance only in the ack cycle.
  - No second request issued while one is outstanding.
- flush two cycles after req with ack 3 cycles later:
  - DRAIN entered, ack data not pushed, pc_advance=0.
  - Queue (2 entries beforehand) empty next cycle.
  - New request at the new pc_in (0x100) afterwards.
- flush coincident with imem_ack and a pop:
  - No push, pc_advance=0, count=0, return to IDLE.
- reset asserted while imem_req=1 and queue holds 3 entries:
  - All outputs zero immediately, without waiting for a clock edge.
  - After release, normal fetch from the current pc_in.
